// File: rtl/lin_frame_tx.sv
// LIN master frame sequencer: drives break and delimiter on the line directly, then hands
// sync, PID, data and checksum bytes to an external byte transmitter one at a time.
module lin_frame_tx #(
  parameter logic [15:0] BIT_DIV    = 16'd5208,
  parameter int unsigned BREAK_BITS = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  frame_id,
  input  logic [3:0]  data_len,
  input  logic [63:0] data,
  input  logic        enhanced,
  output logic        bypass,
  output logic        bypass_data,
  output logic        updata_point,
  output logic        tx_data_req,
  output logic [7:0]  tx_data,
  input  logic        tx_data_ack,
  input  logic        tx_data_err,
  output logic        busy,
  output logic        done,
  output logic        frame_err
);

  typedef enum logic [2:0] {
    StIdle, StBreak, StDelim, StSync, StPid, StData, StCsum, StDone
  } state_e;

  localparam logic [4:0]  BRK_LAST = 5'(BREAK_BITS - 1);
  localparam logic [15:0] BIT_LAST = BIT_DIV - 16'd1;

  state_e      r_state;
  logic [15:0] r_timer;
  logic [4:0]  r_brk;
  logic [2:0]  r_idx;
  logic [7:0]  r_csum;
  logic [5:0]  r_id;
  logic [3:0]  r_len;
  logic [63:0] r_data;
  logic        r_enh;
  logic        r_tx_data_req;
  logic [7:0]  r_tx_data;
  logic        r_frame_err;

  state_e      w_state_d;
  logic [15:0] w_timer_d;
  logic [4:0]  w_brk_d;
  logic [2:0]  w_idx_d;
  logic [2:0]  w_idx_nxt;
  logic        w_req_d;
  logic [7:0]  w_tx_data_d;
  logic        w_fe_d;
  logic        w_cap;
  logic        w_in_frame;
  logic        w_upd;
  logic        w_ack;
  logic [7:0]  w_pid;
  logic [8:0]  w_sum9;
  logic [7:0]  w_csum_add;

  assign w_in_frame = (r_state != StIdle) && (r_state != StDone);
  assign w_upd      = w_in_frame && (r_timer == BIT_LAST);
  // A still-high ack from the previous byte is stale during the load cycle.
  assign w_ack      = tx_data_ack && !r_tx_data_req;
  assign w_idx_nxt  = r_idx + 3'd1;
  assign w_pid      = {~(r_id[1] ^ r_id[3] ^ r_id[4] ^ r_id[5]),
                       r_id[0] ^ r_id[1] ^ r_id[2] ^ r_id[4], r_id};
  assign w_sum9     = {1'b0, r_csum} + {1'b0, r_tx_data};
  assign w_csum_add = w_sum9[7:0] + {7'd0, w_sum9[8]};

  always_comb begin
    w_state_d   = r_state;
    w_brk_d     = r_brk;
    w_idx_d     = r_idx;
    w_req_d     = 1'b0;
    w_tx_data_d = r_tx_data;
    w_fe_d      = r_frame_err;
    w_cap       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_d = StBreak;
          w_cap     = 1'b1;
          w_brk_d   = 5'd0;
          w_fe_d    = 1'b0;
        end
      end
      StBreak: begin
        if (w_upd) begin
          if (r_brk == BRK_LAST) w_state_d = StDelim;
          else                   w_brk_d   = r_brk + 5'd1;
        end
      end
      StDelim: begin
        if (w_upd) begin
          w_state_d   = StSync;
          w_req_d     = 1'b1;
          w_tx_data_d = 8'h55;
        end
      end
      StSync: begin
        if (w_ack) begin
          w_state_d   = StPid;
          w_req_d     = 1'b1;
          w_tx_data_d = w_pid;
        end
      end
      StPid: begin
        if (w_ack) begin
          if (r_len != 4'd0) begin
            w_state_d   = StData;
            w_req_d     = 1'b1;
            w_idx_d     = 3'd0;
            w_tx_data_d = r_data[7:0];
          end else begin
            w_state_d = StDone;
          end
        end
      end
      StData: begin
        if (w_ack) begin
          w_req_d = 1'b1;
          if ({1'b0, r_idx} == r_len - 4'd1) begin
            w_state_d   = StCsum;
            w_tx_data_d = ~r_csum;
          end else begin
            w_idx_d     = w_idx_nxt;
            w_tx_data_d = r_data[{w_idx_nxt, 3'b000} +: 8];
          end
        end
      end
      StCsum: begin
        if (w_ack) w_state_d = StDone;
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
    if (w_in_frame && tx_data_err) begin
      w_state_d   = StDone;
      w_req_d     = 1'b0;
      w_tx_data_d = r_tx_data;
      w_fe_d      = 1'b1;
    end
  end

  always_comb begin
    if (r_state == StIdle || w_state_d == StIdle || w_req_d) w_timer_d = 16'd0;
    else if (r_timer == BIT_LAST)                            w_timer_d = 16'd0;
    else                                                     w_timer_d = r_timer + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= StIdle;
      r_timer       <= 16'd0;
      r_brk         <= 5'd0;
      r_idx         <= 3'd0;
      r_csum        <= 8'd0;
      r_id          <= 6'd0;
      r_len         <= 4'd0;
      r_data        <= 64'd0;
      r_enh         <= 1'b0;
      r_tx_data_req <= 1'b0;
      r_tx_data     <= 8'h00;
      r_frame_err   <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_timer       <= w_timer_d;
      r_brk         <= w_brk_d;
      r_idx         <= w_idx_d;
      r_tx_data_req <= w_req_d;
      r_tx_data     <= w_tx_data_d;
      r_frame_err   <= w_fe_d;
      if (w_cap) begin
        r_id   <= frame_id;
        r_len  <= (data_len > 4'd8) ? 4'd8 : data_len;
        r_data <= data;
        r_enh  <= enhanced;
        r_csum <= 8'd0;
      end else if (r_tx_data_req && (r_state == StData || (r_state == StPid && r_enh))) begin
        r_csum <= w_csum_add;
      end
    end
  end

  assign bypass       = !(r_state inside {StSync, StPid, StData, StCsum});
  assign bypass_data  = (r_state != StBreak);
  assign updata_point = w_upd;
  assign tx_data_req  = r_tx_data_req;
  assign tx_data      = r_tx_data;
  assign busy         = (r_state != StIdle);
  assign done         = (r_state == StDone);
  assign frame_err    = r_frame_err;

endmodule
